// File: rtl/parity_pkg.sv
// Shared definitions for the XOR-parity serial link (receiver today, transmitter later).
// ODD_PARITY_EN selects odd parity; the default build checks even parity.
package parity_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } rx_state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // acc is the XOR of all data bits; p is the received parity bit.
    function automatic logic parity_err_of(input logic acc, input logic p);
`ifdef ODD_PARITY_EN
        return ~(acc ^ p);
`else
        return acc ^ p;
`endif
    endfunction

endpackage

// File: rtl/parity_acc.sv
// Running-XOR flop: cleared at the start of a frame, folds in each sampled data bit.
module parity_acc (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic bit_in,
    output logic acc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= 1'b0;
        end else if (clr) begin
            acc <= 1'b0;
        end else if (en) begin
            acc <= acc ^ bit_in;
        end
    end

endmodule

// File: rtl/parity_rx.sv
// Serial parity receiver: start, DATA_W data bits LSB first, parity, stop; idle line high.
// Parity sense comes from parity_pkg (ODD_PARITY_EN selects odd parity).
module parity_rx
    import parity_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_in,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int TICK_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_W + 1);
    localparam logic [TICK_W-1:0] HALF_TICK = TICK_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_W - 1);

    rx_state_t          state;
    rx_state_t          state_next;
    logic               rx_meta;
    logic               rx_s;
    logic [TICK_W-1:0]  tick;
    logic [BIT_W-1:0]   bit_cnt;
    logic [DATA_W-1:0]  shift;
    logic               p_bit;
    logic               acc;
    logic               sample_pt;
    logic               acc_clr;
    logic               acc_en;
    logic               stop_take;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (rx_s == START_BIT) state_next = ST_START;
            ST_START:  if (sample_pt) state_next = (rx_s == START_BIT) ? ST_DATA : ST_IDLE;
            ST_DATA:   if (sample_pt && bit_cnt == LAST_BIT) state_next = ST_PARITY;
            ST_PARITY: if (sample_pt) state_next = ST_STOP;
            ST_STOP:   if (sample_pt) state_next = (rx_s == STOP_BIT) ? ST_IDLE : ST_BREAK;
            ST_BREAK:  if (rx_s == STOP_BIT) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // The start bit is checked half a bit in; every later bit one full bit after that.
    always_comb begin
        sample_pt = (state == ST_START) ? (tick == HALF_TICK) : (tick == LAST_TICK);
        busy      = (state != ST_IDLE);
        acc_clr   = (state == ST_START);
        acc_en    = (state == ST_DATA) && sample_pt;
        stop_take = (state == ST_STOP) && sample_pt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick    <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            p_bit   <= 1'b0;
        end else begin
            if (state == ST_IDLE || state == ST_BREAK || sample_pt) begin
                tick <= '0;
            end else begin
                tick <= tick + 1'b1;
            end

            if (state == ST_IDLE) begin
                bit_cnt <= '0;
            end else if (acc_en) begin
                bit_cnt <= bit_cnt + 1'b1;
                for (int i = 0; i < DATA_W; i++) begin
                    if (bit_cnt == BIT_W'(i)) shift[i] <= rx_s;
                end
            end

            if (state == ST_PARITY && sample_pt) begin
                p_bit <= rx_s;
            end
        end
    end

    parity_acc u_acc (
        .clk    (clk),
        .rst    (rst),
        .clr    (acc_clr),
        .en     (acc_en),
        .bit_in (rx_s),
        .acc    (acc)
    );

    // Result registers: flags only live for the single rx_valid cycle, data holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_valid   <= 1'b0;
            rx_data    <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_valid <= stop_take;
            if (stop_take) begin
                rx_data    <= shift;
                parity_err <= parity_err_of(acc, p_bit);
                frame_err  <= (rx_s != STOP_BIT);
            end else begin
                parity_err <= 1'b0;
                frame_err  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_parity_rx.sv
// Bench for parity_rx: frames are built bit by bit, the model predicts each result word,
// its arrival cycle and the busy window from the frame layout alone.
module tb_parity_rx;

  localparam int DATA_W = 8;
  localparam int CPB    = 4;
  localparam int HALF   = CPB / 2;
  // Cycles from the first clock edge that sees the start bit to rx_valid.
  localparam int LAT    = 2 + HALF + CPB * (DATA_W + 2);
  localparam int NEVER  = 32'h7fffffff;
`ifdef ODD_PARITY_EN
  localparam logic ODD = 1'b1;
`else
  localparam logic ODD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rx_in = 1'b1;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              parity_err;
  logic              frame_err;
  logic              busy;

  parity_rx #(.DATA_W(DATA_W), .CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_in      (rx_in),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [DATA_W-1:0] exp_q[$];
  int                ev_cyc_q[$];
  logic              ev_perr_q[$];
  logic              ev_ferr_q[$];
  int                win_lo_q[$];
  int                win_hi_q[$];
  logic [DATA_W-1:0] last_data = '0;
  int                n_vec = 0;
  int                n_err = 0;
  int                pulse_cnt = 0;
  logic [DATA_W-1:0] cap_data = '0;
  logic              cap_perr = 1'b0;
  logic              cap_ferr = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic void model_reset();
    exp_q.delete();
    ev_cyc_q.delete();
    ev_perr_q.delete();
    ev_ferr_q.delete();
    win_lo_q.delete();
    win_hi_q.delete();
    last_data = '0;
  endfunction

  // compare process
  logic cmp_ev, cmp_ep, cmp_ef, cmp_eb;
  always @(negedge clk) begin
    if (rst) begin
      check("rst_valid", rx_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_data", rx_data, 0);
      check("rst_perr", parity_err, 0);
      check("rst_ferr", frame_err, 0);
    end else begin
      cmp_ev = 1'b0;
      cmp_ep = 1'b0;
      cmp_ef = 1'b0;
      while (win_hi_q.size() > 0 && win_hi_q[0] < cyc) begin
        void'(win_lo_q.pop_front());
        void'(win_hi_q.pop_front());
      end
      cmp_eb = (win_lo_q.size() > 0) && (win_lo_q[0] <= cyc);
      if (ev_cyc_q.size() > 0 && ev_cyc_q[0] <= cyc) begin
        void'(ev_cyc_q.pop_front());
        cmp_ev    = 1'b1;
        last_data = exp_q.pop_front();
        cmp_ep    = ev_perr_q.pop_front();
        cmp_ef    = ev_ferr_q.pop_front();
      end
      if (rx_valid) begin
        pulse_cnt++;
        cap_data = rx_data;
        cap_perr = parity_err;
        cap_ferr = frame_err;
      end
      check("rx_valid", rx_valid, cmp_ev);
      check("rx_data", rx_data, last_data);
      check("parity_err", parity_err, cmp_ep);
      check("frame_err", frame_err, cmp_ef);
      check("busy", busy, cmp_eb);
    end
  end

  // driver tasks: inputs change 1 time unit after a rising edge
  task automatic wait_cycles(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] d, input logic p, input logic s,
                            input int extra_low, input int gap);
    int f;
    f = cyc + 1;
    ev_cyc_q.push_back(f + LAT);
    exp_q.push_back(d);
    ev_perr_q.push_back((^d) ^ p ^ ODD);
    ev_ferr_q.push_back(~s);
    win_lo_q.push_back(f + 2);
    win_hi_q.push_back(s ? f + LAT - 1 : NEVER);
    rx_in = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < DATA_W; i++) begin
      rx_in = d[i];
      wait_cycles(CPB);
    end
    rx_in = p;
    wait_cycles(CPB);
    rx_in = s;
    wait_cycles(CPB);
    if (!s) begin
      wait_cycles(extra_low);
      rx_in = 1'b1;
      win_hi_q[win_hi_q.size() - 1] = cyc + 2;
    end
    rx_in = 1'b1;
    wait_cycles(gap);
  endtask

  task automatic send_glitch(input int gap);
    int f;
    f = cyc + 1;
    win_lo_q.push_back(f + 2);
    win_hi_q.push_back(f + 1 + HALF);
    rx_in = 1'b0;
    wait_cycles(1);
    rx_in = 1'b1;
    wait_cycles(gap);
  endtask

  task automatic reset_mid_frame(input logic [DATA_W-1:0] d);
    int f;
    f = cyc + 1;
    win_lo_q.push_back(f + 2);
    win_hi_q.push_back(NEVER);
    rx_in = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 3; i++) begin
      rx_in = d[i];
      wait_cycles(CPB);
    end
    rx_in = d[3];
    wait_cycles(2);
    model_reset();
    rst   = 1'b1;
    rx_in = 1'b1;
    #1;
    check("abort_valid", rx_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_data", rx_data, 0);
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(4);
  endtask

  // stimulus
  int p_before;
  int budget;
  logic [DATA_W-1:0] rd;
  logic rp;
  initial begin
    rst   = 1'b1;
    rx_in = 1'b1;
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(3);

`ifdef ODD_PARITY_EN
    send_frame(8'hA5, 1'b1, 1'b1, 0, 4);
    check("odd_a5_p1_data", cap_data, 8'hA5);
    check("odd_a5_p1_perr", cap_perr, 0);
    send_frame(8'hA5, 1'b0, 1'b1, 0, 4);
    check("odd_a5_p0_perr", cap_perr, 1);
`else
    send_frame(8'hA5, 1'b0, 1'b1, 0, 4);
    check("a5_data", cap_data, 8'hA5);
    check("a5_perr", cap_perr, 0);
    check("a5_ferr", cap_ferr, 0);
    check("a5_pulses", pulse_cnt, 1);
    send_frame(8'h01, 1'b0, 1'b1, 0, 4);
    check("01_data", cap_data, 8'h01);
    check("01_perr", cap_perr, 1);
`endif

    p_before = pulse_cnt;
    send_frame(8'hFF, 1'b0, 1'b0, 3 * CPB, 4);
    check("break_ferr", cap_ferr, 1);
    check("break_one_pulse", pulse_cnt - p_before, 1);

    p_before = pulse_cnt;
    send_glitch(HALF + 4);
    check("glitch_no_pulse", pulse_cnt - p_before, 0);

    reset_mid_frame(8'h96);
    send_frame(8'h3C, ODD, 1'b1, 0, 4);
    check("3c_data", cap_data, 8'h3C);
    check("3c_perr", cap_perr, 0);
    check("3c_ferr", cap_ferr, 0);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 9))
        0: send_glitch($urandom_range(HALF + 2, HALF + 6));
        1: send_frame(DATA_W'($urandom), 1'($urandom), 1'b0,
                      $urandom_range(0, 2 * CPB), $urandom_range(2, 6));
        default: begin
          rd = DATA_W'($urandom);
          rp = ($urandom_range(0, 3) == 0) ? ~((^rd) ^ ODD) : ((^rd) ^ ODD);
          send_frame(rd, rp, 1'b1, 0, $urandom_range(2, 6));
        end
      endcase
    end

    budget = 200;
    while (ev_cyc_q.size() > 0 && budget > 0) begin
      wait_cycles(1);
      budget--;
    end
    check("drain_pending", ev_cyc_q.size(), 0);
    wait_cycles(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog at cycle %0d: got no finish, expected finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
